vdc_vram_port: RTL
==================

# vdc_vram_port

HuC6270 VRAM access port. It sits directly downstream of the VDC CPU-bus control unit. It consumes decoded register byte strobes for MAWR (0x00), MARR (0x01) and VWR/VRR (0x02), maintains the write and read address registers with auto-increment, and issues single-word VRAM reads and writes to the VRAM arbiter over a req/gnt handshake. It holds one operation in flight plus one pending, and reports BUSY back to the CPU side.

## Interface
Parameters:
- ADDR_W, 16: VRAM word address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16: VRAM word width; fixed at two CPU bytes.

Ports:
- clock  in  1  system clock; single clock domain.
- reset_n  in  1  reset, synchronous, active-low.
- reg_sel  in  5  register currently selected by the control unit's address register.
- wr_lsb / wr_msb  in  1  one-cycle pulses: CPU writes the low / high byte of reg_sel.
- rd_lsb / rd_msb  in  1  one-cycle pulses: CPU reads the low / high byte of reg_sel.
- di  in  8  CPU write byte, valid with wr_*.
- do  out  8  CPU read byte, combinational, valid in the same cycle as rd_*.
- incr_sel  in  2  CR[12:11] increment width: 00→1, 01→32, 10→64, 11→128.
- busy_n  out  1  low while an operation is active or pending.
- overrun  out  1  sticky; a trigger was dropped.
- vram_req  out  1  access request.
- vram_we  out  1  1 = write, 0 = read; stable while vram_req is high.
- vram_addr  out  ADDR_W  access address; stable while vram_req is high.
- vram_wdata  out  DATA_W  write data; stable while vram_req is high.
- vram_gnt  in  1  arbiter accepts the request this cycle.
- vram_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- vram_rdata  in  DATA_W  read data.

## Operation
- Register writes:
  - MAWR and MARR: byte-wise loads from di.
  - VWR LSB: loads the write latch low byte.
- Triggers:
  - A write of VWR MSB issues a write trigger: addr = MAWR, data = {di, latch_lo}.
  - A write of MARR MSB issues a read trigger: addr = the newly loaded MARR.
  - A read of VRR MSB (rd_msb with reg_sel 0x02) issues a read trigger: addr = MARR.
- Address increment and capture:
  - On the trigger cycle, address and data are captured into an op slot.
  - In the same cycle, the source register is incremented by the incr_sel step, modulo 2^ADDR_W.
  - Later MAWR/MARR writes never affect captured ops.
- Op slots: one active slot and one pending slot.
  - A trigger when idle goes to the active slot.
  - A trigger when active goes to the pending slot.
  - A trigger when both slots are full is dropped, its increment is still applied, and overrun is set.
- FSM:
  - IDLE: on active valid → REQ.
  - REQ: vram_req=1; on gnt, a write → DONE and a read → RWAIT.
  - RWAIT: on rvalid, load the VRR latch → DONE.
  - DONE: promote pending to active if present → REQ, else → IDLE.
- Reads: do returns the VRR latch byte for reg_sel 0x02. Any other reg_sel returns 0x00.
- Register read-back: MAWR and MARR are write-only.

## Timing
- Reset: all registers and latches are 0, FSM is IDLE, busy_n=1, overrun=0, vram_req=0, vram_we=0, vram_addr=0, vram_wdata=0, do=0.
- Reset mid-operation: vram_req drops at the next edge, and any rvalid arriving later is ignored.
- Trigger at cycle T: vram_req=1 at T+1, and busy_n=0 from T+1.
- Write completion: a write granted at cycle G completes at G+1 (DONE). busy_n returns to 1 at G+2 if nothing is pending.
- Read completion: with rvalid at cycle V, the VRR latch is visible on do at V+1, and busy_n returns to 1 at V+2 if nothing is pending.
- Back-to-back: a pending op asserts vram_req in the cycle after DONE.
- Simultaneous events:
  - A trigger arriving in the DONE cycle is treated as arriving while active.
  - rd_lsb in the same cycle as rvalid returns the old latch value.

## Configuration
- VDC_VRAM_INCR_EN defined: increment step is decoded from incr_sel as listed above.
- VDC_VRAM_INCR_EN undefined: the increment step is always 1, and incr_sel is ignored.

## Structure
- Package vdc_pkg holds:
  - the reg_sel_t constants REG_MAWR=5'h00, REG_MARR=5'h01, REG_VWR=5'h02;
  - the incr_t encoding;
  - the vram_state_t enum {IDLE, REQ, RWAIT, DONE};
  - the vram_op_t struct {we, addr, data}.
- One sub-module, vdc_vram_op_queue: the two-entry active/pending slot holding vram_op_t, with push/pop/full/empty outputs and overrun generation.

## Test plan
- Write 0x0100 to MAWR, 0x34 to VWR LSB, 0x12 to VWR MSB, with gnt held high → one write at addr 0x0100 with data 0x1234; MAWR reads back internally as 0x0101; busy_n is low for 2 cycles.
- Set incr_sel=01 and write MARR = 0xFFF0, with rdata 0xBEEF returned 2 cycles after gnt → rd_lsb/rd_msb return 0xEF/0xBE; rd_msb causes the next read at addr 0x0010 (wrap).
- Hold gnt low and issue 3 VWR MSB writes → the first two are queued, the third is dropped, overrun=1, MAWR advances by 3.
- Pulse reset_n low during RWAIT, then pulse rvalid → vram_req=0, busy_n=1, VRR latch is 0, do=0x00.
- Read reg_sel 0x05 → do=0x00 and no VRAM request.
- Build without VDC_VRAM_INCR_EN and with incr_sel=11, write MAWR = 0x0000, then issue two VWR MSB writes → writes go to addr 0x0000 and 0x0001.

Source files
------------

// File: rtl/vdc_pkg.sv
// Shared types and constants for the VDC VRAM access port.
package vdc_pkg;

    localparam int VDC_ADDR_W = 16;
    localparam int VDC_DATA_W = 16;

    typedef logic [4:0] reg_sel_t;

    localparam reg_sel_t REG_MAWR = 5'h00;
    localparam reg_sel_t REG_MARR = 5'h01;
    localparam reg_sel_t REG_VWR  = 5'h02;

    typedef enum logic [1:0] {
        INCR_1   = 2'b00,
        INCR_32  = 2'b01,
        INCR_64  = 2'b10,
        INCR_128 = 2'b11
    } incr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RWAIT,
        DONE
    } vram_state_t;

    typedef struct packed {
        logic                  we;
        logic [VDC_ADDR_W-1:0] addr;
        logic [VDC_DATA_W-1:0] data;
    } vram_op_t;

    function automatic logic [7:0] incr_step(input incr_t sel);
        case (sel)
            INCR_32:  return 8'd32;
            INCR_64:  return 8'd64;
            INCR_128: return 8'd128;
            default:  return 8'd1;
        endcase
    endfunction

endpackage

// File: rtl/vdc_vram_op_queue.sv
// Two-entry op holder: the active slot feeds the VRAM FSM, the pending slot
// queues one more; a push while both are occupied is dropped and flagged.
module vdc_vram_op_queue
    import vdc_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     push,
    input  vram_op_t push_op,
    input  logic     pop,
    output vram_op_t act_op,
    output logic     full,
    output logic     empty,
    output logic     overrun
);

    vram_op_t pend_op;
    logic     act_vld;
    logic     pend_vld;

    assign full  = act_vld & pend_vld;
    assign empty = ~act_vld;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            act_op   <= '0;
            pend_op  <= '0;
            act_vld  <= 1'b0;
            pend_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (push && full)
                overrun <= 1'b1;
            // A pop frees the active slot before the incoming push is placed.
            if (pop) begin
                if (pend_vld) begin
                    act_op   <= pend_op;
                    act_vld  <= 1'b1;
                    pend_vld <= 1'b0;
                end else if (push) begin
                    act_op  <= push_op;
                    act_vld <= 1'b1;
                end else begin
                    act_vld <= 1'b0;
                end
            end else if (push) begin
                if (!act_vld) begin
                    act_op  <= push_op;
                    act_vld <= 1'b1;
                end else if (!pend_vld) begin
                    pend_op  <= push_op;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vdc_vram_port.sv
// HuC6270 VRAM access port: MAWR/MARR/VWR/VRR handling and arbiter handshake.
// Optional build macro VDC_VRAM_INCR_EN enables the CR[12:11] increment width.
module vdc_vram_port
    import vdc_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [4:0]        reg_sel,
    input  logic              wr_lsb,
    input  logic              wr_msb,
    input  logic              rd_lsb,
    input  logic              rd_msb,
    input  logic [7:0]        di,
    output logic [7:0]        dout,   // CPU read byte ("do" is a reserved word)
    input  logic [1:0]        incr_sel,
    output logic              busy_n,
    output logic              overrun,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic              vram_gnt,
    input  logic              vram_rvalid,
    input  logic [DATA_W-1:0] vram_rdata
);

    vram_state_t       state;
    vram_state_t       state_nx;
    logic [ADDR_W-1:0] mawr;
    logic [ADDR_W-1:0] marr;
    logic [ADDR_W-1:0] marr_new;
    logic [ADDR_W-1:0] step;
    logic [7:0]        latch_lo;
    logic [DATA_W-1:0] vrr_latch;
    logic              sel_mawr;
    logic              sel_marr;
    logic              sel_vwr;
    logic              vwr_trig;
    logic              marr_trig;
    logic              vrr_trig;
    logic              push;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    vram_op_t          push_op;
    vram_op_t          act_op;

    function automatic logic [ADDR_W-1:0] set_byte(input logic [ADDR_W-1:0] cur,
                                                   input logic hi,
                                                   input logic [7:0] b);
        logic [15:0] w;
        w = 16'(cur);
        if (hi)
            w[15:8] = b;
        else
            w[7:0] = b;
        return ADDR_W'(w);
    endfunction

`ifdef VDC_VRAM_INCR_EN
    assign step = ADDR_W'(incr_step(incr_t'(incr_sel)));
`else
    logic incr_unused;
    assign incr_unused = ^incr_sel;
    assign step        = ADDR_W'(1);
`endif

    assign sel_mawr  = (reg_sel == REG_MAWR);
    assign sel_marr  = (reg_sel == REG_MARR);
    assign sel_vwr   = (reg_sel == REG_VWR);
    assign vwr_trig  = wr_msb & sel_vwr;
    assign marr_trig = wr_msb & sel_marr;
    assign vrr_trig  = rd_msb & sel_vwr;
    assign push      = vwr_trig | marr_trig | vrr_trig;
    assign marr_new  = set_byte(marr, 1'b1, di);

    always_comb begin
        push_op = '0;
        if (vwr_trig) begin
            push_op.we   = 1'b1;
            push_op.addr = VDC_ADDR_W'(mawr);
            push_op.data = VDC_DATA_W'({di, latch_lo});
        end else if (marr_trig) begin
            push_op.addr = VDC_ADDR_W'(marr_new);
        end else if (vrr_trig) begin
            push_op.addr = VDC_ADDR_W'(marr);
        end
    end

    // Address registers step on the same edge the op is captured.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mawr      <= '0;
            marr      <= '0;
            latch_lo  <= '0;
            vrr_latch <= '0;
        end else begin
            if (wr_lsb && sel_mawr)
                mawr <= set_byte(mawr, 1'b0, di);
            if (wr_msb && sel_mawr)
                mawr <= set_byte(mawr, 1'b1, di);
            if (vwr_trig)
                mawr <= mawr + step;
            if (wr_lsb && sel_marr)
                marr <= set_byte(marr, 1'b0, di);
            if (marr_trig)
                marr <= marr_new + step;
            if (vrr_trig)
                marr <= marr + step;
            if (wr_lsb && sel_vwr)
                latch_lo <= di;
            if (state == RWAIT && vram_rvalid)
                vrr_latch <= vram_rdata;
        end
    end

    vdc_vram_op_queue u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .push_op (push_op),
        .pop     (pop),
        .act_op  (act_op),
        .full    (q_full),
        .empty   (q_empty),
        .overrun (overrun)
    );

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // In DONE a still-full queue means a pending op will be promoted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (push) state_nx = REQ;
            REQ:     if (vram_gnt) state_nx = act_op.we ? DONE : RWAIT;
            RWAIT:   if (vram_rvalid) state_nx = DONE;
            DONE:    state_nx = (q_full || push) ? REQ : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        vram_req = (state == REQ);
        pop      = (state == DONE);
    end

    assign vram_we    = act_op.we;
    assign vram_addr  = ADDR_W'(act_op.addr);
    assign vram_wdata = DATA_W'(act_op.data);
    assign busy_n     = q_empty;

    always_comb begin
        dout = 8'h00;
        if (sel_vwr)
            dout = rd_msb ? vrr_latch[15:8] : vrr_latch[7:0];
    end

endmodule
